// File: rtl/rhd_spi_slave_gen.sv
// Behavioural model of one RHD2000-family amplifier chip seen from a single MISO line.
// Optional macro RHD_LFSR_NOISE_EN adds LFSR noise to the low nibble of CONVERT results.
module rhd_spi_slave_gen #(
  parameter int STARTING_SEED = 0,
  parameter int NUM_CH        = 64,
  parameter int SYNC_STAGES   = 2,
  parameter int PIPE_DEPTH    = 2,
  parameter int CHIP_ID       = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        SCLK,
  input  logic        MOSI,
  input  logic        CS,
  output logic        MISO,
  output logic        cmd_valid,
  output logic [15:0] cmd_word,
  output logic        frame_error,
  output logic [15:0] convert_count
);

  logic [SYNC_STAGES-1:0] sclkSync_q, csSync_q, mosiSync_q;
  logic        sclkPrev_q, csPrev_q, inFrame_q;
  logic [4:0]  bitCnt_q;
  logic [15:0] rxShift_q, txShift_q;
  logic [15:0] pipe_q [PIPE_DEPTH];
  logic [7:0]  regFile_q [40];
  logic [15:0] convCnt_q, cmdWord_q;
  logic        miso_q, cmdValid_q, frameErr_q;
`ifdef RHD_LFSR_NOISE_EN
  logic [15:0] lfsr_q;
`endif

  logic sclkS, csS, mosiS, sclkRise, sclkFall, csFall, csRise;
  assign sclkS    = sclkSync_q[SYNC_STAGES-1];
  assign csS      = csSync_q[SYNC_STAGES-1];
  assign mosiS    = mosiSync_q[SYNC_STAGES-1];
  assign sclkRise = sclkS & ~sclkPrev_q;
  assign sclkFall = ~sclkS & sclkPrev_q;
  assign csFall   = ~csS & csPrev_q;
  assign csRise   = csS & ~csPrev_q;

  function automatic logic [7:0] romRead(input logic [5:0] r);
    case (r)
      6'd40:   romRead = 8'h49;
      6'd41:   romRead = 8'h4E;
      6'd42:   romRead = 8'h54;
      6'd43:   romRead = 8'h41;
      6'd44:   romRead = 8'h4E;
      6'd60:   romRead = 8'h01;
      6'd61:   romRead = 8'h00;
      6'd62:   romRead = 8'(NUM_CH);
      6'd63:   romRead = 8'(CHIP_ID);
      default: romRead = 8'h00;
    endcase
  endfunction

  logic [5:0]  cmdC;
  logic [7:0]  wrData, romVal, regVal;
  logic [15:0] rsp_d;
  logic        wrEn_d, isConv_d, cntInc_d;

  // CALIBRATE, CLEAR and every unrecognised word share the all-zero response.
  always_comb begin
    cmdC     = rxShift_q[13:8];
    wrData   = rxShift_q[7:0];
    romVal   = romRead(cmdC);
    regVal   = (cmdC < 6'd40) ? regFile_q[cmdC] : romVal;
    rsp_d    = 16'h0000;
    wrEn_d   = 1'b0;
    isConv_d = 1'b0;
    cntInc_d = 1'b0;
    case (rxShift_q[15:14])
      2'b00: begin
        isConv_d = 1'b1;
        cntInc_d = (cmdC == 6'd0);
        if (int'(cmdC) < NUM_CH) begin
          rsp_d = 16'(STARTING_SEED) + {10'd0, cmdC} + convCnt_q;
`ifdef RHD_LFSR_NOISE_EN
          rsp_d[3:0] = rsp_d[3:0] ^ lfsr_q[3:0];
`endif
        end
      end
      2'b10: begin
        if (cmdC < 6'd40) begin
          wrEn_d = 1'b1;
          rsp_d  = {8'hFF, wrData};
        end else begin
          rsp_d  = {8'hFF, romVal};
        end
      end
      2'b11:   rsp_d = {8'h00, regVal};
      default: rsp_d = 16'h0000;
    endcase
  end

  // inFrame_q gates everything so a frame cut by reset is ignored until the next CS fall.
  always_ff @(posedge clk) begin
    if (rst) begin
      sclkSync_q <= '0;
      csSync_q   <= '0;
      mosiSync_q <= '0;
      sclkPrev_q <= 1'b0;
      csPrev_q   <= 1'b0;
      inFrame_q  <= 1'b0;
      bitCnt_q   <= 5'd0;
      rxShift_q  <= 16'h0000;
      txShift_q  <= 16'h0000;
      convCnt_q  <= 16'h0000;
      cmdWord_q  <= 16'h0000;
      miso_q     <= 1'b0;
      cmdValid_q <= 1'b0;
      frameErr_q <= 1'b0;
      for (int i = 0; i < PIPE_DEPTH; i++) pipe_q[i] <= 16'h0000;
      for (int i = 0; i < 40; i++) regFile_q[i] <= 8'h00;
`ifdef RHD_LFSR_NOISE_EN
      lfsr_q     <= 16'hACE1;
`endif
    end else begin
      sclkSync_q <= {sclkSync_q[SYNC_STAGES-2:0], SCLK};
      csSync_q   <= {csSync_q[SYNC_STAGES-2:0], CS};
      mosiSync_q <= {mosiSync_q[SYNC_STAGES-2:0], MOSI};
      sclkPrev_q <= sclkS;
      csPrev_q   <= csS;
      cmdValid_q <= 1'b0;
      frameErr_q <= 1'b0;
      if (csFall) begin
        inFrame_q <= 1'b1;
        txShift_q <= pipe_q[PIPE_DEPTH-1];
        miso_q    <= pipe_q[PIPE_DEPTH-1][15];
        if (sclkRise) begin
          bitCnt_q  <= 5'd1;
          rxShift_q <= {rxShift_q[14:0], mosiS};
        end else begin
          bitCnt_q  <= 5'd0;
        end
      end else if (inFrame_q && csRise) begin
        inFrame_q <= 1'b0;
        if (bitCnt_q == 5'd16) begin
          cmdValid_q <= 1'b1;
          cmdWord_q  <= rxShift_q;
          for (int i = PIPE_DEPTH - 1; i > 0; i--) pipe_q[i] <= pipe_q[i-1];
          pipe_q[0] <= rsp_d;
          if (wrEn_d) regFile_q[cmdC] <= wrData;
          if (cntInc_d) convCnt_q <= convCnt_q + 16'd1;
`ifdef RHD_LFSR_NOISE_EN
          if (isConv_d)
            lfsr_q <= {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
`endif
        end else begin
          frameErr_q <= 1'b1;
        end
      end else if (inFrame_q) begin
        if (sclkRise) begin
          rxShift_q <= {rxShift_q[14:0], mosiS};
          if (bitCnt_q != 5'd16) bitCnt_q <= bitCnt_q + 5'd1;
        end
        if (sclkFall) begin
          txShift_q <= {txShift_q[14:0], 1'b0};
          miso_q    <= txShift_q[14];
        end
      end
    end
  end

  assign MISO          = miso_q;
  assign cmd_valid     = cmdValid_q;
  assign cmd_word      = cmdWord_q;
  assign frame_error   = frameErr_q;
  assign convert_count = convCnt_q;

`ifndef RHD_LFSR_NOISE_EN
  logic unusedConv;
  assign unusedConv = isConv_d;
`endif

endmodule

// File: tb/tb_rhd_spi_slave_gen.sv
// Directed bench for rhd_spi_slave_gen: SPI frames driven bit by bit, MISO words checked against hand-computed values.
module tb_rhd_spi_slave_gen;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        SCLK = 1'b0;
  logic        MOSI = 1'b0;
  logic        CS = 1'b1;
  logic        MISO;
  logic        cmd_valid;
  logic [15:0] cmd_word;
  logic        frame_error;
  logic [15:0] convert_count;

  int checks = 0;
  int errors = 0;
  int validCnt = 0;
  int errPulseCnt = 0;

  rhd_spi_slave_gen #(
    .STARTING_SEED(144),
    .NUM_CH(32),
    .SYNC_STAGES(2),
    .PIPE_DEPTH(2),
    .CHIP_ID(1)
  ) dut (
    .clk(clk),
    .rst(rst),
    .SCLK(SCLK),
    .MOSI(MOSI),
    .CS(CS),
    .MISO(MISO),
    .cmd_valid(cmd_valid),
    .cmd_word(cmd_word),
    .frame_error(frame_error),
    .convert_count(convert_count)
  );

  always #5 clk = ~clk;

  // Pulse counters sampled on the falling edge, away from the DUT's update edge.
  always @(negedge clk) begin
    if (cmd_valid) validCnt++;
    if (frame_error) errPulseCnt++;
  end

  task automatic waitClk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic csLow();
    CS = 1'b0;
    waitClk(4);
  endtask

  task automatic sendBit(input logic b, output logic m);
    MOSI = b;
    waitClk(4);
    m = MISO;
    SCLK = 1'b1;
    waitClk(4);
    SCLK = 1'b0;
  endtask

  task automatic csHigh();
    MOSI = 1'b0;
    waitClk(4);
    CS = 1'b1;
    waitClk(8);
  endtask

  task automatic spiFrame(input logic [15:0] w, output logic [15:0] r);
    logic m;
    csLow();
    for (int i = 15; i >= 0; i--) begin
      sendBit(w[i], m);
      r[i] = m;
    end
    csHigh();
  endtask

  task automatic doReset();
    rst = 1'b1;
    CS = 1'b1;
    SCLK = 1'b0;
    MOSI = 1'b0;
    waitClk(4);
    rst = 1'b0;
    waitClk(6);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    waitClk(3);
    if (MISO !== 1'b0) begin $display("[TB] FAIL reset_miso: got %b expected 0", MISO); errors++; end
    checks++;
    if (cmd_valid !== 1'b0) begin $display("[TB] FAIL reset_cmd_valid: got %b expected 0", cmd_valid); errors++; end
    checks++;
    if (cmd_word !== 16'h0000) begin $display("[TB] FAIL reset_cmd_word: got %h expected 0000", cmd_word); errors++; end
    checks++;
    if (frame_error !== 1'b0) begin $display("[TB] FAIL reset_frame_error: got %b expected 0", frame_error); errors++; end
    checks++;
    if (convert_count !== 16'h0000) begin $display("[TB] FAIL reset_convert_count: got %h expected 0000", convert_count); errors++; end
    checks++;
    doReset();
  endtask

  task automatic test_read_rom();
    logic [15:0] cmds [8] = '{16'hE800, 16'hE900, 16'hEA00, 16'hEB00, 16'hFE00, 16'hFF00, 16'h6A00, 16'h6A00};
    logic [15:0] exps [8] = '{16'h0000, 16'h0000, 16'h0049, 16'h004E, 16'h0054, 16'h0041, 16'h0020, 16'h0001};
    logic [15:0] r;
    doReset();
    for (int i = 0; i < 8; i++) begin
      spiFrame(cmds[i], r);
      if (r !== exps[i]) begin $display("[TB] FAIL rom_frame%0d: got %h expected %h", i, r, exps[i]); errors++; end
      checks++;
    end
    if (cmd_word !== 16'h6A00) begin $display("[TB] FAIL rom_cmd_word: got %h expected 6a00", cmd_word); errors++; end
    checks++;
  endtask

  task automatic test_write_read();
    logic [15:0] cmds [4] = '{16'h85A7, 16'hC500, 16'h6A00, 16'h6A00};
    logic [15:0] exps [4] = '{16'h0000, 16'h0000, 16'hFFA7, 16'h00A7};
    logic [15:0] r;
    int v0;
    doReset();
    v0 = validCnt;
    for (int i = 0; i < 4; i++) begin
      spiFrame(cmds[i], r);
      if (r !== exps[i]) begin $display("[TB] FAIL wr_frame%0d: got %h expected %h", i, r, exps[i]); errors++; end
      checks++;
      if (i == 0 && cmd_word !== 16'h85A7) begin $display("[TB] FAIL wr_cmd_word: got %h expected 85a7", cmd_word); errors++; end
      if (i == 0) checks++;
    end
    if (validCnt - v0 !== 4) begin $display("[TB] FAIL wr_valid_pulses: got %0d expected 4", validCnt - v0); errors++; end
    checks++;
  endtask

  task automatic test_convert();
    logic [15:0] cmds [5] = '{16'h0000, 16'h0100, 16'h0000, 16'h6A00, 16'h6A00};
    logic [15:0] exps [5] = '{16'h0000, 16'h0000, 16'h0090, 16'h0092, 16'h0091};
    logic [15:0] r;
    doReset();
    for (int i = 0; i < 5; i++) begin
      spiFrame(cmds[i], r);
      if (r !== exps[i]) begin $display("[TB] FAIL conv_frame%0d: got %h expected %h", i, r, exps[i]); errors++; end
      checks++;
      if (i == 2 && convert_count !== 16'd2) begin $display("[TB] FAIL conv_count: got %0d expected 2", convert_count); errors++; end
      if (i == 2) checks++;
    end
  endtask

  task automatic test_bounds();
    logic [15:0] cmds [6] = '{16'h1F00, 16'h3F00, 16'hA912, 16'hE900, 16'h6A00, 16'h6A00};
    logic [15:0] exps [6] = '{16'h0000, 16'h0000, 16'h00AF, 16'h0000, 16'hFF4E, 16'h004E};
    logic [15:0] r;
    doReset();
    for (int i = 0; i < 6; i++) begin
      spiFrame(cmds[i], r);
      if (r !== exps[i]) begin $display("[TB] FAIL bounds_frame%0d: got %h expected %h", i, r, exps[i]); errors++; end
      checks++;
    end
  endtask

  task automatic test_frame_error();
    logic [15:0] cmds [4] = '{16'h873C, 16'hC700, 16'h6A00, 16'h6A00};
    logic [15:0] exps [4] = '{16'h0000, 16'h0000, 16'hFF3C, 16'h003C};
    logic [15:0] partial = 16'hC700;
    logic [15:0] r;
    logic m;
    int v0, e0;
    doReset();
    spiFrame(cmds[0], r);
    if (r !== exps[0]) begin $display("[TB] FAIL ferr_frame0: got %h expected %h", r, exps[0]); errors++; end
    checks++;
    v0 = validCnt;
    e0 = errPulseCnt;
    csLow();
    for (int i = 15; i >= 7; i--) sendBit(partial[i], m);
    csHigh();
    if (errPulseCnt - e0 !== 1) begin $display("[TB] FAIL ferr_pulse: got %0d expected 1", errPulseCnt - e0); errors++; end
    checks++;
    if (validCnt - v0 !== 0) begin $display("[TB] FAIL ferr_no_valid: got %0d expected 0", validCnt - v0); errors++; end
    checks++;
    if (cmd_word !== 16'h873C) begin $display("[TB] FAIL ferr_cmd_word: got %h expected 873c", cmd_word); errors++; end
    checks++;
    for (int i = 1; i < 4; i++) begin
      spiFrame(cmds[i], r);
      if (r !== exps[i]) begin $display("[TB] FAIL ferr_frame%0d: got %h expected %h", i, r, exps[i]); errors++; end
      checks++;
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [15:0] w = 16'h8355;
    logic [15:0] r;
    logic m;
    int v0, e0;
    doReset();
    v0 = validCnt;
    e0 = errPulseCnt;
    csLow();
    for (int i = 15; i >= 8; i--) sendBit(w[i], m);
    rst = 1'b1;
    waitClk(3);
    rst = 1'b0;
    for (int i = 7; i >= 0; i--) sendBit(w[i], m);
    csHigh();
    if (errPulseCnt - e0 !== 0) begin $display("[TB] FAIL mid_no_ferr: got %0d expected 0", errPulseCnt - e0); errors++; end
    checks++;
    if (validCnt - v0 !== 0) begin $display("[TB] FAIL mid_no_valid: got %0d expected 0", validCnt - v0); errors++; end
    checks++;
    if (cmd_word !== 16'h0000) begin $display("[TB] FAIL mid_cmd_word: got %h expected 0000", cmd_word); errors++; end
    checks++;
    for (int i = 0; i < 3; i++) begin
      spiFrame(16'hC300, r);
      if (r !== 16'h0000) begin $display("[TB] FAIL mid_read%0d: got %h expected 0000", i, r); errors++; end
      checks++;
    end
  endtask

  initial begin
    test_reset();
    test_read_rom();
    test_write_read();
    test_convert();
    test_bounds();
    test_frame_error();
    test_reset_mid_frame();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
